// File: rtl/trace_stream_arbiter.sv
// Round-robin arbiter sharing one cpu_checker between two trace-character
// sources. One source is granted per '^' ... '#' message; its characters are
// forwarded one per clock on chk_char, and the checker's verdict is returned
// tagged with the source id. Over-long messages are aborted and flushed.
module trace_stream_arbiter #(
  parameter int unsigned MAX_LEN = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        src0_valid,
  input  logic [7:0]  src0_char,
  output logic        src0_ready,
  input  logic        src1_valid,
  input  logic [7:0]  src1_char,
  output logic        src1_ready,
  input  logic [15:0] freq,
  output logic [7:0]  chk_char,
  output logic [15:0] chk_freq,
  input  logic [1:0]  chk_format,
  input  logic [3:0]  chk_error,
  output logic        res_valid,
  output logic        res_src,
  output logic [1:0]  res_format,
  output logic [3:0]  res_error,
  output logic [1:0]  res_status,
  output logic        busy
);

  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam logic [7:0]  END_CHAR = 8'h23;  // '#'
  localparam logic [LW-1:0] LAST_LEN = LW'(MAX_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    WAIT_RES,
    FLUSH
  } state_t;

  state_t        state;
  logic          ptr;
  logic          grant_id;
  logic          gap;
  logic          wcnt;
  logic [LW-1:0] len;

  logic          cur_valid;
  logic [7:0]    cur_char;
  logic          taking;

  // Select the granted source and decide which source may hand over a char.
  always_comb begin
    cur_valid  = grant_id ? src1_valid : src0_valid;
    cur_char   = grant_id ? src1_char  : src0_char;
    taking     = (state == STREAM) || (state == FLUSH);
    src0_ready = taking && !grant_id;
    src1_ready = taking &&  grant_id;
  end

  assign chk_freq = freq;
  assign busy     = (state != IDLE);

  // Message sequencing: grant, stream, wait for the checker verdict or flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      grant_id   <= 1'b0;
      gap        <= 1'b0;
      wcnt       <= 1'b0;
      len        <= '0;
      chk_char   <= '0;
      res_valid  <= 1'b0;
      res_src    <= 1'b0;
      res_format <= '0;
      res_error  <= '0;
      res_status <= '0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          chk_char <= '0;
          if (src0_valid || src1_valid) begin
            if (src0_valid && src1_valid) begin
              grant_id <= ptr;
            end else begin
              grant_id <= src1_valid;
            end
            len   <= '0;
            gap   <= 1'b0;
            state <= STREAM;
          end
        end

        STREAM: begin
          if (cur_valid) begin
            chk_char <= cur_char;
            len      <= len + LW'(1);
            if (cur_char == END_CHAR) begin
              wcnt  <= 1'b0;
              state <= WAIT_RES;
            end else if (len == LAST_LEN) begin
              state <= FLUSH;
            end
          end else begin
            chk_char <= '0;
            gap      <= 1'b1;
          end
        end

        // '#' is on chk_char during the first WAIT_RES cycle; the checker's
        // verdict is stable during the second, where it is captured.
        WAIT_RES: begin
          chk_char <= '0;
          if (wcnt) begin
            res_valid  <= 1'b1;
            res_src    <= grant_id;
            res_format <= chk_format;
            res_error  <= chk_error;
            res_status <= {gap, 1'b0};
            ptr        <= ~grant_id;
            state      <= IDLE;
          end else begin
            wcnt <= 1'b1;
          end
        end

        FLUSH: begin
          chk_char <= '0;
          if (cur_valid && (cur_char == END_CHAR)) begin
            res_valid  <= 1'b1;
            res_src    <= grant_id;
            res_format <= '0;
            res_error  <= '0;
            res_status <= {gap, 1'b1};
            ptr        <= ~grant_id;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_stream_arbiter.sv
// Bench for trace_stream_arbiter: directed message sequence plus randomized
// messages, a stand-in checker that answers only for the cycle after it sees
// '#', and a message-level reference model of forwarding and results.
module tb_trace_stream_arbiter;

  localparam int unsigned MAX_LEN = 64;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [1:0] fmt;
    logic [3:0] err;
  } verdict_t;
  typedef struct {
    logic        src;
    logic [1:0]  fmt;
    logic [3:0]  err;
    logic [1:0]  status;
    int unsigned due;
  } result_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        src0_valid, src1_valid;
  logic [7:0]  src0_char, src1_char;
  logic        src0_ready, src1_ready;
  logic [15:0] freq, chk_freq;
  logic [7:0]  chk_char;
  logic [1:0]  chk_format;
  logic [3:0]  chk_error;
  logic        res_valid, res_src;
  logic [1:0]  res_format, res_status;
  logic [3:0]  res_error;
  logic        busy;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;

  verdict_t    chkq[$];
  result_t     resq[$];
  logic        res_src_log[$];
  int unsigned pos[2];
  logic [7:0]  exp_chk = 8'h00;
  logic [1:0]  desc_fmt[2];
  logic [3:0]  desc_err[2];
  logic        desc_gap[2];
  logic        saw_zero = 1'b0;

  trace_stream_arbiter #(.MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .reset(reset),
    .src0_valid(src0_valid), .src0_char(src0_char), .src0_ready(src0_ready),
    .src1_valid(src1_valid), .src1_char(src1_char), .src1_ready(src1_ready),
    .freq(freq), .chk_char(chk_char), .chk_freq(chk_freq),
    .chk_format(chk_format), .chk_error(chk_error),
    .res_valid(res_valid), .res_src(res_src), .res_format(res_format),
    .res_error(res_error), .res_status(res_status), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stand-in checker: verdict appears the cycle after '#' is seen, rejected
  // (0) if a 0x00 arrived since '^'; otherwise drives noise.
  always @(posedge clk) begin
    verdict_t v;
    if (chk_char == 8'h5e) saw_zero <= 1'b0;
    else if (chk_char == 8'h00) saw_zero <= 1'b1;
    if (chk_char == 8'h23 && chkq.size() > 0) begin
      v = chkq.pop_front();
      chk_format <= saw_zero ? 2'd0 : v.fmt;
      chk_error  <= saw_zero ? 4'd0 : v.err;
    end else begin
      chk_format <= 2'($urandom);
      chk_error  <= 4'($urandom);
    end
  end

  // Reference model: per-message char positions decide forwarding, and each
  // accepted '#' schedules one expected result.
  always @(negedge clk) begin
    logic        acc;
    logic [7:0]  c;
    logic        ab;
    result_t     r;
    if (reset) begin
      pos[0] = 0;
      pos[1] = 0;
      exp_chk = 8'h00;
      resq.delete();
      chkq.delete();
    end else begin
      chk("chk_char", 32'(chk_char), 32'(exp_chk));
      chk("ready_onehot", 32'(src0_ready & src1_ready), 32'd0);
      chk("chk_freq", 32'(chk_freq), 32'(freq));
      if (res_valid) begin
        if (resq.size() == 0) begin
          chk("res_unexpected", 32'(res_valid), 32'd0);
        end else begin
          r = resq.pop_front();
          chk("res_time", 32'(cyc), 32'(r.due));
          chk("res_src", 32'(res_src), 32'(r.src));
          chk("res_format", 32'(res_format), 32'(r.fmt));
          chk("res_error", 32'(res_error), 32'(r.err));
          chk("res_status", 32'(res_status), 32'(r.status));
          res_src_log.push_back(res_src);
        end
      end else if (resq.size() > 0 && cyc > resq[0].due) begin
        chk("res_missing", 32'(res_valid), 32'd1);
        void'(resq.pop_front());
      end
      exp_chk = 8'h00;
      for (int unsigned s = 0; s < 2; s++) begin
        acc = (s == 0) ? (src0_valid & src0_ready) : (src1_valid & src1_ready);
        c   = (s == 0) ? src0_char : src1_char;
        if (acc) begin
          pos[s] = pos[s] + 1;
          if (pos[s] <= MAX_LEN) exp_chk = c;
          if (c == 8'h23) begin
            ab = (pos[s] > MAX_LEN);
            if (!ab) chkq.push_back('{desc_fmt[s], desc_err[s]});
            r.src    = (s == 1);
            r.fmt    = (ab || desc_gap[s]) ? 2'd0 : desc_fmt[s];
            r.err    = (ab || desc_gap[s]) ? 4'd0 : desc_err[s];
            r.status = {desc_gap[s], ab};
            r.due    = ab ? cyc + 1 : cyc + 3;
            resq.push_back(r);
            pos[s] = 0;
          end
        end
      end
    end
  end

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(8'(s[i]));
    return q;
  endfunction

  function automatic logic [7:0] rand_char();
    logic [7:0] c;
    do c = 8'($urandom_range(126, 32)); while (c == 8'h23 || c == 8'h5e);
    return c;
  endfunction

  function automatic bq_t rand_msg(input int n);
    bq_t q;
    q.push_back(8'h5e);
    for (int i = 0; i < n; i++) q.push_back(rand_char());
    q.push_back(8'h23);
    return q;
  endfunction

  task automatic set_src(input logic s, input logic v, input logic [7:0] c);
    if (s) begin src1_valid = v; src1_char = c; end
    else   begin src0_valid = v; src0_char = c; end
  endtask

  task automatic wait_accept(input logic s);
    int   n = 0;
    logic acc;
    do begin
      @(negedge clk);
      acc = s ? src1_ready : src0_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 300);
    if (!acc) chk(s ? "accept_timeout1" : "accept_timeout0", 32'(acc), 32'd1);
  endtask

  // gap_at: index of the char preceded by one valid-low cycle (-1 = none).
  task automatic send_msg(input logic s, input bq_t msg, input int gap_at,
                          input logic [1:0] fmt, input logic [3:0] err);
    desc_fmt[s] = fmt;
    desc_err[s] = err;
    desc_gap[s] = (gap_at >= 0);
    for (int i = 0; i < msg.size(); i++) begin
      if (i == gap_at) begin
        set_src(s, 1'b0, 8'h00);
        @(posedge clk); #1;
      end
      set_src(s, 1'b1, msg[i]);
      wait_accept(s);
    end
    set_src(s, 1'b0, 8'h00);
  endtask

  task automatic send_rand(input logic s);
    int n;
    int g;
    n = $urandom_range(70, 2);
    g = ($urandom_range(3, 0) == 0) ? $urandom_range((n < 40) ? n : 40, 1) : -1;
    send_msg(s, rand_msg(n), g, 2'($urandom_range(3, 1)), 4'($urandom));
  endtask

  task automatic drain();
    int n = 0;
    while ((resq.size() != 0 || busy) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", 32'(resq.size()), 32'd0);
    @(posedge clk); #1;
    chk("drain_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    bq_t m1, m3;
    m1 = str2q("^10@00003000: $1 <= 0000000a#");
    m3 = str2q("^16@00001000: *00003001 <= 00000000#");
    reset = 1'b1;
    src0_valid = 1'b0; src0_char = 8'h00;
    src1_valid = 1'b0; src1_char = 8'h00;
    freq = 16'd4;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_chk_char", 32'(chk_char), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_fields", 32'({res_src, res_format, res_error, res_status}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'({src0_ready, src1_ready}), 32'd0);
    reset = 1'b0;

    // Register-write message from source 0.
    send_msg(1'b0, m1, -1, 2'd1, 4'd0);
    drain();

    // Both sources valid from reset release: strict alternation.
    reset = 1'b1;
    @(posedge clk); #1;
    res_src_log.delete();
    fork
      begin
        for (int i = 0; i < 2; i++)
          send_msg(1'b0, rand_msg($urandom_range(12, 3)), -1, 2'($urandom_range(3, 1)), 4'($urandom));
      end
      begin
        for (int i = 0; i < 2; i++)
          send_msg(1'b1, rand_msg($urandom_range(12, 3)), -1, 2'($urandom_range(3, 1)), 4'($urandom));
      end
      begin
        @(posedge clk); #1;
        reset = 1'b0;
      end
    join
    drain();
    chk("rr_count", 32'(res_src_log.size()), 32'd4);
    for (int i = 0; i < res_src_log.size() && i < 4; i++)
      chk("rr_order", 32'(res_src_log[i]), 32'(i % 2));

    // Memory-write message from source 1 at a different frequency.
    freq = 16'd64;
    send_msg(1'b1, m3, -1, 2'd2, 4'b0111);
    drain();

    // Gap right after '@': checker rejects, gap flagged.
    freq = 16'd4;
    send_msg(1'b0, m1, 4, 2'd1, 4'd0);
    drain();

    // Length boundary: '#' at position 64 passes, at 65 is flushed.
    send_msg(1'b0, rand_msg(62), -1, 2'd3, 4'd5);
    drain();
    send_msg(1'b1, rand_msg(63), -1, 2'd3, 4'd5);
    drain();

    // 70 chars without '#': flushed, then source 1 checks normally.
    send_msg(1'b0, rand_msg(69), -1, 2'd1, 4'd2);
    drain();
    send_msg(1'b1, rand_msg(10), -1, 2'd2, 4'd9);
    drain();

    // Reset mid-stream drops the partial message.
    desc_fmt[0] = 2'd1; desc_err[0] = 4'd0; desc_gap[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_src(1'b0, 1'b1, m1[i]);
      wait_accept(1'b0);
    end
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_chk_char", 32'(chk_char), 32'd0);
    chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'({src0_ready, src1_ready}), 32'd0);
    set_src(1'b0, 1'b0, 8'h00);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send_msg(1'b0, m1, -1, 2'd1, 4'd0);
    drain();

    // Randomized traffic from both sources.
    for (int it = 0; it < 10; it++) begin
      fork
        send_rand(1'b0);
        send_rand(1'b1);
      join
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
